// File: rtl/du_ctrl_pkg.sv
// rtl/du_ctrl_pkg.sv - shared state encodings and dump index constants for du_exec_controller
package du_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_DUMP      = 3'd4,
        ST_DONE      = 3'd5
    } exec_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_ADDR = 2'd1,
        SEQ_SEND = 2'd2
    } seq_state_e;

    localparam int DEF_N_REGS      = 32;
    localparam int DEF_N_MEM_WORDS = 32;

    // Dump word order: PC, cycle count, register file, then data memory.
    localparam int IDX_PC         = 0;
    localparam int IDX_CYCLES     = 1;
    localparam int IDX_REG_BASE   = 2;
    localparam int IDX_MEM_BASE   = IDX_REG_BASE + DEF_N_REGS;
    localparam int DUMP_LEN_NOMEM = IDX_MEM_BASE;
    localparam int DUMP_LEN_MEM   = IDX_MEM_BASE + DEF_N_MEM_WORDS;

endpackage

// File: rtl/du_exec_controller_if.sv
// rtl/du_exec_controller_if.sv - debug-read and transmit-word bus between controller, pipeline and serializer
interface du_exec_controller_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_MEM_ADDR = 5
);
    logic [NB_REG_ADDR-1:0] o_reg_addr;
    logic [NB_DATA-1:0]     i_reg_data;
    logic [NB_MEM_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0]     i_mem_data;
    logic [NB_DATA-1:0]     o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;

    modport master (
        output o_reg_addr, o_mem_addr, o_tx_data, o_tx_valid,
        input  i_reg_data, i_mem_data, i_tx_ready
    );

    modport slave (
        input  o_reg_addr, o_mem_addr, o_tx_data, o_tx_valid,
        output i_reg_data, i_mem_data, i_tx_ready
    );
endinterface

// File: rtl/du_dump_sequencer.sv
// rtl/du_dump_sequencer.sv - word-by-word state dump with ADDR/SEND phasing; DU_DUMP_MEM_EN appends data memory
module du_dump_sequencer
    import du_ctrl_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int N_REGS      = 32,
    parameter int NB_MEM_ADDR = 5,
    parameter int N_MEM_WORDS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_cycles,
    output logic               o_finish,
    du_exec_controller_if.master bus
);

`ifdef DU_DUMP_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif
    localparam int MEM_BASE = IDX_REG_BASE + N_REGS;
    localparam int LEN      = MEM_BASE + (MEM_EN ? N_MEM_WORDS : 0);
    localparam int NB_IDX   = $clog2(LEN + 1);

    localparam logic [NB_IDX-1:0] I_PC   = NB_IDX'(IDX_PC);
    localparam logic [NB_IDX-1:0] I_CYC  = NB_IDX'(IDX_CYCLES);
    localparam logic [NB_IDX-1:0] I_REG  = NB_IDX'(IDX_REG_BASE);
    localparam logic [NB_IDX-1:0] I_MEM  = NB_IDX'(MEM_BASE);
    localparam logic [NB_IDX-1:0] I_LAST = NB_IDX'(LEN - 1);

    seq_state_e             seq_q, seq_d;
    logic [NB_IDX-1:0]      idx_q, idx_d, idx_nx;
    logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [NB_DATA-1:0]     tx_data_q, tx_data_d, src;
    logic                   tx_valid_q, tx_valid_d;

`ifndef DU_DUMP_MEM_EN
    logic unused_mem_data;
    assign unused_mem_data = ^bus.i_mem_data;
`endif

    // Sequencer registers; reset aborts any word in flight
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            seq_q      <= SEQ_IDLE;
            idx_q      <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Phase sequencing: addresses are set on entry to ADDR so the read data settles before SEND captures it
    always_comb begin
        seq_d      = seq_q;
        idx_d      = idx_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        o_finish   = 1'b0;
        idx_nx     = idx_q + 1'b1;

        src = bus.i_reg_data;
        if (idx_q == I_PC) begin
            src = i_pc;
        end else if (idx_q == I_CYC) begin
            src = i_cycles;
`ifdef DU_DUMP_MEM_EN
        end else if (idx_q >= I_MEM) begin
            src = bus.i_mem_data;
`endif
        end

        case (seq_q)
            SEQ_IDLE: begin
                if (i_start) begin
                    seq_d = SEQ_ADDR;
                    idx_d = '0;
                end
            end
            SEQ_ADDR: begin
                seq_d      = SEQ_SEND;
                tx_data_d  = src;
                tx_valid_d = 1'b1;
            end
            SEQ_SEND: begin
                if (tx_valid_q && bus.i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == I_LAST) begin
                        o_finish   = 1'b1;
                        seq_d      = SEQ_IDLE;
                        idx_d      = '0;
                        reg_addr_d = '0;
                        mem_addr_d = '0;
                    end else begin
                        seq_d = SEQ_ADDR;
                        idx_d = idx_nx;
                        if (idx_nx >= I_REG && idx_nx < I_MEM) begin
                            reg_addr_d = NB_REG_ADDR'(idx_nx - I_REG);
`ifdef DU_DUMP_MEM_EN
                        end else if (idx_nx >= I_MEM) begin
                            mem_addr_d = NB_MEM_ADDR'(idx_nx - I_MEM);
`endif
                        end
                    end
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    assign bus.o_reg_addr = reg_addr_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_valid = tx_valid_q;

endmodule

// File: rtl/du_exec_controller.sv
// rtl/du_exec_controller.sv - debug-unit execution sequencer for the MIPS pipeline; DU_DUMP_MEM_EN enables memory dump
module du_exec_controller
    import du_ctrl_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int N_REGS      = 32,
    parameter int NB_MEM_ADDR = 5,
    parameter int N_MEM_WORDS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_mode_valid,
    input  logic               i_mode,
    input  logic               i_step,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_pc,
    output logic               o_cpu_enable,
    output logic [NB_DATA-1:0] o_cycles,
    output logic [2:0]         o_state,
    output logic               o_done,
    du_exec_controller_if.master dbg
);

    exec_state_e        state_q, state_d;
    logic               cpu_enable_q, cpu_enable_d;
    logic [NB_DATA-1:0] cycles_q, cycles_d;
    logic               halt_q, halt_d;
    logic               done_q, done_d;
    logic               dump_start, dump_finish;

    // Control registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            cpu_enable_q <= 1'b0;
            cycles_q     <= '0;
            halt_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_enable_q <= cpu_enable_d;
            cycles_q     <= cycles_d;
            halt_q       <= halt_d;
            done_q       <= done_d;
        end
    end

    // Next state, saturating cycle count and halt latch; halt only counts while the pipeline is enabled
    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        halt_d     = halt_q;
        dump_start = 1'b0;

        if (cpu_enable_q && (cycles_q != '1)) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_mode_valid) begin
                    cycles_d = '0;
                    halt_d   = 1'b0;
                    state_d  = i_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_enable_q && i_halt) begin
                    halt_d     = 1'b1;
                    state_d    = ST_DUMP;
                    dump_start = 1'b1;
                end
            end
            ST_STEP_WAIT: begin
                if (i_step) begin
                    state_d = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                if (cpu_enable_q && i_halt) begin
                    halt_d = 1'b1;
                end
                state_d    = ST_DUMP;
                dump_start = 1'b1;
            end
            ST_DUMP: begin
                if (dump_finish) begin
                    state_d = halt_q ? ST_DONE : ST_STEP_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cpu_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
        done_d       = (state_d == ST_DONE);
    end

    du_dump_sequencer #(
        .NB_DATA     (NB_DATA),
        .NB_REG_ADDR (NB_REG_ADDR),
        .N_REGS      (N_REGS),
        .NB_MEM_ADDR (NB_MEM_ADDR),
        .N_MEM_WORDS (N_MEM_WORDS)
    ) u_dump (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (dump_start),
        .i_pc     (i_pc),
        .i_cycles (cycles_q),
        .o_finish (dump_finish),
        .bus      (dbg)
    );

    assign o_cpu_enable = cpu_enable_q;
    assign o_cycles     = cycles_q;
    assign o_state      = state_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_du_exec_controller.sv
// tb/tb_du_exec_controller.sv - directed self-checking bench for du_exec_controller
module tb_du_exec_controller;

`ifdef DU_DUMP_MEM_EN
    localparam int N = 66;
`else
    localparam int N = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_valid, mode, step, halt, tx_ready;
    logic [31:0] pc_val;
    logic        cpu_enable, done;
    logic [31:0] cycles;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] words[$];
    int en_cnt = 0;
    int dump_cyc = 0;
    int unstable = 0;
    logic        pend = 1'b0;
    logic [31:0] pdata = '0;

    du_exec_controller_if #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_MEM_ADDR(5)) dbg ();

    du_exec_controller dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_mode_valid (mode_valid),
        .i_mode       (mode),
        .i_step       (step),
        .i_halt       (halt),
        .i_pc         (pc_val),
        .o_cpu_enable (cpu_enable),
        .o_cycles     (cycles),
        .o_state      (state),
        .o_done       (done),
        .dbg          (dbg)
    );

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return 32'hA500_0000 | (32'(a) * 32'h101);
    endfunction

    function automatic logic [31:0] mem_val(input logic [4:0] a);
        return 32'h5A00_0000 | (32'(a) * 32'h11);
    endfunction

    function automatic logic [31:0] exp_word(input int k, input logic [31:0] cyc, input logic [31:0] pc);
        if (k == 0) return pc;
        if (k == 1) return cyc;
        if (k < 34) return reg_val(5'(k - 2));
        return mem_val(5'(k - 34));
    endfunction

    assign dbg.i_reg_data = reg_val(dbg.o_reg_addr);
    assign dbg.i_mem_data = mem_val(dbg.o_mem_addr);
    assign dbg.i_tx_ready = tx_ready;

    always #5 clk = ~clk;

    // Passive observer just before each rising edge: transferred words, enabled cycles, dump length, data stability
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend && (dbg.o_tx_data !== pdata)) unstable = unstable + 1;
            if (dbg.o_tx_valid && !tx_ready) begin
                pend  = 1'b1;
                pdata = dbg.o_tx_data;
            end else begin
                pend = 1'b0;
            end
            if (dbg.o_tx_valid && tx_ready) words.push_back(dbg.o_tx_data);
            if (cpu_enable) en_cnt = en_cnt + 1;
            if (state == 3'd4) dump_cyc = dump_cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_mode(input logic m);
        @(negedge clk);
        mode_valid = 1'b1;
        mode       = m;
        @(negedge clk);
        mode_valid = 1'b0;
    endtask

    task automatic do_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step_exec_state", 32'(state), 32'd3);
        chk("step_exec_enable", 32'(cpu_enable), 32'd1);
        @(negedge clk);
        chk("step_dump_state", 32'(state), 32'd4);
        chk("step_dump_enable", 32'(cpu_enable), 32'd0);
    endtask

    task automatic wait_dump(input int base, input bit toggle, input bit inject);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            tx_ready = toggle ? (c % 4 == 0) : 1'b1;
            if (inject && c == 5) begin
                mode_valid = 1'b1;
                mode       = 1'b0;
                step       = 1'b1;
            end
            if (inject && c == 6) begin
                mode_valid = 1'b0;
                step       = 1'b0;
                chk("ignored_cmd_state", 32'(state), 32'd4);
            end
            if ((words.size() - base) >= N && state != 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        chk("dump_complete", 32'(ok), 32'd1);
    endtask

    task automatic check_words(input int base, input logic [31:0] cyc, input logic [31:0] pc);
        chk("word_count", 32'(words.size() - base), 32'(N));
        for (int k = 0; k < N; k++) begin
            if (base + k < words.size())
                chk($sformatf("word%0d", k), words[base + k], exp_word(k, cyc, pc));
        end
    endtask

    initial begin
        int base, en0, dc0, un0;
        bit seen;
        rst_n = 1'b0; mode_valid = 1'b0; mode = 1'b0; step = 1'b0; halt = 1'b0;
        tx_ready = 1'b1; pc_val = 32'h0000_0040;

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enable", 32'(cpu_enable), 32'd0);
        chk("rst_tx_valid", 32'(dbg.o_tx_valid), 32'd0);
        chk("rst_tx_data", dbg.o_tx_data, 32'd0);
        chk("rst_reg_addr", 32'(dbg.o_reg_addr), 32'd0);
        chk("rst_mem_addr", 32'(dbg.o_mem_addr), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Reset mid-RUN
        pulse_mode(1'b0);
        repeat (4) @(negedge clk);
        chk("run_state", 32'(state), 32'd1);
        chk("run_enable", 32'(cpu_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_enable", 32'(cpu_enable), 32'd0);
        chk("arst_cycles", cycles, 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release_state", 32'(state), 32'd0);

        // Step mode: three steps, second with throttled ready, third with ignored commands
        pulse_mode(1'b1);
        chk("step_wait_state", 32'(state), 32'd2);
        chk("step_wait_enable", 32'(cpu_enable), 32'd0);
        for (int s = 1; s <= 3; s++) begin
            repeat (20) @(negedge clk);
            pc_val = 32'h100 * s;
            base = words.size(); en0 = en_cnt; dc0 = dump_cyc; un0 = unstable;
            do_step();
            wait_dump(base, s == 2, s == 3);
            check_words(base, 32'(s), pc_val);
            chk("step_en_cycles", 32'(en_cnt - en0), 32'd1);
            chk("step_back_wait", 32'(state), 32'd2);
            chk("step_cycles", cycles, 32'(s));
            if (s == 1) chk("dump_len_cycles", 32'(dump_cyc - dc0), 32'(2 * N));
            if (s == 2) chk("tx_data_stable", 32'(unstable - un0), 32'd0);
        end

        // Fourth step retires HALT
        halt = 1'b1;
        repeat (3) @(negedge clk);
        base = words.size();
        do_step();
        wait_dump(base, 1'b0, 1'b0);
        check_words(base, 32'd4, pc_val);
        chk("halt_step_state", 32'(state), 32'd5);
        chk("halt_step_done", 32'(done), 32'd1);

        // Continuous mode, halt 10 cycles after enable rises
        halt = 1'b0;
        pc_val = 32'h0000_0ABC;
        base = words.size(); en0 = en_cnt;
        pulse_mode(1'b0);
        chk("cont_state", 32'(state), 32'd1);
        chk("cont_cycles_clr", cycles, 32'd0);
        chk("cont_done_clr", 32'(done), 32'd0);
        repeat (10) @(negedge clk);
        halt = 1'b1;
        wait_dump(base, 1'b0, 1'b0);
        check_words(base, 32'd11, pc_val);
        chk("cont_cycles", cycles, 32'd11);
        chk("cont_en_cycles", 32'(en_cnt - en0), 32'd11);
        chk("cont_state_done", 32'(state), 32'd5);
        chk("cont_done", 32'(done), 32'd1);

        // Reset while a word is pending
        tx_ready = 1'b0;
        pulse_mode(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dbg.o_tx_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_valid_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", 32'(dbg.o_tx_valid), 32'd0);
        chk("abort_tx_data", dbg.o_tx_data, 32'd0);
        chk("abort_reg_addr", 32'(dbg.o_reg_addr), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        halt = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/du_exec_controller.md
# du_exec_controller

Sequences the MIPS pipeline under debug-unit command. It gates the pipeline enable for continuous or single-step execution, and counts executed cycles. After each step, or on halt, it drives a word-by-word dump of PC, cycle count, register file and data memory toward the UART transmit path. It sits between the debug unit command decoder, the pipeline's enable/debug-read ports and the UART word serializer.

## Interface
Parameters:
- NB_DATA, 32, width of every dumped word and of the cycle counter
- NB_REG_ADDR, 5, register-file debug read address width
- N_REGS, 32, registers dumped
- NB_MEM_ADDR, 5, data-memory debug read address width
- N_MEM_WORDS, 32, memory words dumped

Ports:
- i_clock  in  1  single clock
- i_reset  in  1  asynchronous, active-low reset
- i_mode_valid  in  1  one-cycle pulse, new execution command
- i_mode  in  1  qualified by i_mode_valid: 0 continuous, 1 step
- i_step  in  1  one-cycle pulse, execute one pipeline cycle
- i_halt  in  1  pipeline retired a HALT instruction (level)
- i_pc  in  NB_DATA  current PC
- i_reg_data  in  NB_DATA  combinational read of register o_reg_addr
- i_mem_data  in  NB_DATA  combinational read of memory word o_mem_addr
- i_tx_ready  in  1  serializer can accept a word
- o_cpu_enable  out  1  pipeline clock enable
- o_reg_addr  out  NB_REG_ADDR  register debug read address
- o_mem_addr  out  NB_MEM_ADDR  memory debug read address
- o_tx_data  out  NB_DATA  word to transmit
- o_tx_valid  out  1  o_tx_data valid
- o_cycles  out  NB_DATA  enabled-cycle count
- o_state  out  3  current state encoding
- o_done  out  1  program finished, dump complete

## Operation
- States (o_state): IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DUMP=4, DONE=5.
- IDLE/DONE: i_mode_valid clears o_cycles and halt latch. Next state is RUN (mode 0) or STEP_WAIT (mode 1). i_mode_valid is ignored in every other state.
- RUN: o_cpu_enable=1. i_halt sampled high sets the halt latch, and the next state is DUMP.
- STEP_WAIT: o_cpu_enable=0. i_step moves to STEP_EXEC. i_step is ignored in all other states.
- STEP_EXEC: exactly one cycle with o_cpu_enable=1. If i_halt is high, the halt latch is set. Next state is DUMP.
- i_halt is sampled only while o_cpu_enable=1.
- DUMP: word index 0=PC, 1=o_cycles, 2..N_REGS+1=registers 0..N_REGS-1, then memory words 0..N_MEM_WORDS-1.
- DUMP exit: next state is DONE if the halt latch is set, else STEP_WAIT. Continuous mode therefore dumps once, at halt.
- Cycle counter: +1 every cycle o_cpu_enable=1; saturates at all-ones, never wraps.
- Outputs not used in the current state hold their last value; o_reg_addr/o_mem_addr return to 0 on DUMP exit.

## Timing
- Reset values: state IDLE, o_cpu_enable 0, o_tx_valid 0, o_tx_data 0, o_reg_addr 0, o_mem_addr 0, o_cycles 0, o_done 0, halt latch 0.
- All outputs are registered; o_state reflects the current state register.
- o_cpu_enable rises the cycle after the RUN or STEP_EXEC entry edge. Exactly one enabled cycle per i_step.
- In RUN, o_cpu_enable falls the cycle after i_halt is sampled; the halting cycle is counted.
- Each dump word is sent in two phases:
  - ADDR phase (1 cycle): drive o_reg_addr/o_mem_addr.
  - SEND phase: capture the selected source into o_tx_data and assert o_tx_valid.
- Handshake: transfer occurs on the edge where o_tx_valid && i_tx_ready. o_tx_data is held stable until then, and o_tx_valid drops the cycle after transfer. Minimum 2 cycles per word.
- i_tx_ready held high: the dump takes 2×(2+N_REGS+N_MEM_WORDS) cycles.
- o_done is 1 only in DONE.
- Asynchronous reset mid-dump aborts immediately: o_tx_valid=0 with no partial word.

## Configuration
- DU_DUMP_MEM_EN defined: the memory words are appended to the dump (66 words at default parameters).
- DU_DUMP_MEM_EN undefined: the dump ends after the last register (34 words), o_mem_addr is tied to 0, and i_mem_data is unused.

## Structure
- Package du_ctrl_pkg holds:
  - state encodings
  - dump index constants: IDX_PC, IDX_CYCLES, IDX_REG_BASE, IDX_MEM_BASE, and dump length with and without memory
- Sub-module du_dump_sequencer holds the word-index counter, ADDR/SEND phasing, address generation and valid/ready handshake, with start/finish pulses to the top FSM.

## Test plan
- Reset with i_reset=0 mid-RUN → all outputs are at their reset values, and o_state=0 on release.
- Mode 0, i_halt high 10 cycles after enable rises, i_tx_ready=1 → o_cycles=11, then 66 words: PC, 11, registers 0..31, memory 0..31; o_done=1, o_state=5.
- Mode 1, three i_step pulses 20 cycles apart → each gives exactly one o_cpu_enable cycle and a full dump; the cycle word reads 1, 2, 3.
- i_tx_ready toggled 1-of-4 cycles during a dump → o_tx_data is stable while o_tx_valid=1, there are no dropped or duplicated words, and word order is unchanged.
- i_mode_valid and i_step pulsed during DUMP → both ignored; the state sequence is unchanged.
- Macro undefined, mode 0, halt → exactly 34 words, then DONE.
